pipe_ctrl: RTL and testbench

- Central pipeline controller that drives the PC register's jump_flag, jump_addr and hold_flag inputs, plus the IF/ID flush line.
- Arbitrates redirect sources (EX-stage branch/jump, external interrupt) and stall sources (EX multicycle op, instruction-bus wait).
- Sequences interrupt entry (wait for bus idle, redirect, flush) and post-redirect flush bubbles.
- Sits beside pc_reg; all outputs are registered.

---
 rtl/pipe_ctrl_pkg.sv | 35 +++
 rtl/pipe_ctrl_perf.sv | 27 ++
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: hold bitmask values,
// jump enables, reset polarity and the controller state encoding.
package pipe_ctrl_pkg;

    // Hold bitmask bits: bit0 holds the PC, bit1 holds IF, bit2 holds ID.
    localparam logic [2:0] HOLD_NONE  = 3'b000;
    localparam logic [2:0] HOLD_PC    = 3'b001;
    localparam logic [2:0] HOLD_IF    = 3'b010;
    localparam logic [2:0] HOLD_ID    = 3'b100;
    localparam logic [2:0] HOLD_FRONT = HOLD_PC | HOLD_IF;
    localparam logic [2:0] HOLD_ALL   = HOLD_PC | HOLD_IF | HOLD_ID;

    localparam logic JUMP_ENABLE  = 1'b1;
    localparam logic JUMP_DISABLE = 1'b0;

    // Reset is active-low.
    localparam logic RST_ENABLE = 1'b0;

    typedef enum logic [1:0] {
        CTRL_IDLE     = 2'd0,
        CTRL_IRQ_WAIT = 2'd1,
        CTRL_FLUSH    = 2'd2
    } ctrl_state_t;

    // Stall mask when idle: an EX multicycle op freezes PC, IF and ID;
    // a bus wait only freezes the front end.
    function automatic logic [2:0] idle_hold(input logic ex_hold, input logic bus_hold);
        logic [2:0] h;
        h = HOLD_NONE;
        if (ex_hold) h = h | HOLD_ALL;
        if (bus_hold) h = h | HOLD_FRONT;
        return h;
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Performance counters for pipe_ctrl: redirect pulses and stalled cycles.
// Only instantiated when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_perf
    import pipe_ctrl_pkg::*;
#(
    parameter int HOLD_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag,
    input  logic [HOLD_W-1:0] hold_flag,
    output logic [31:0]       redirect_cnt,
    output logic [31:0]       stall_cnt
);

    // Free-running wrap-around counters driven by the registered controller outputs.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            redirect_cnt <= 32'd0;
            stall_cnt    <= 32'd0;
        end else begin
            if (jump_flag) redirect_cnt <= redirect_cnt + 32'd1;
            if (|hold_flag) stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: arbitrates redirects (EX jump, interrupt) and
// stalls (EX multicycle, bus wait), and sequences post-redirect flushes.
// All outputs are registered. `state` exposes the FSM for debug.
// Optional macro PIPE_CTRL_PERF_EN adds redirect_cnt / stall_cnt outputs.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int HOLD_W       = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_jump_req,
    input  logic [ADDR_W-1:0] ex_jump_addr,
    input  logic              ex_hold_req,
    input  logic              bus_hold_req,
    input  logic              irq_req,
    input  logic [ADDR_W-1:0] irq_vector,
    input  logic [ADDR_W-1:0] cur_pc,
    output logic              jump_flag,
    output logic [ADDR_W-1:0] jump_addr,
    output logic [HOLD_W-1:0] hold_flag,
    output logic              flush,
    output logic              irq_ack,
    output logic [ADDR_W-1:0] irq_epc,
    output logic [1:0]        state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       redirect_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    // Flush counter preload: the redirect cycle itself is the first flush cycle.
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    ctrl_state_t st;
    logic [3:0]  cnt;
    logic        do_ex;
    logic        do_irq;

    assign state = st;

    // Redirect decision for this cycle; EX redirect always beats the interrupt.
    always_comb begin
        do_ex  = 1'b0;
        do_irq = 1'b0;
        case (st)
            CTRL_IDLE: begin
                do_ex  = ex_jump_req;
                do_irq = !ex_jump_req && irq_req && !ex_hold_req && !bus_hold_req;
            end
            CTRL_IRQ_WAIT: begin
                do_ex  = ex_jump_req;
                do_irq = !ex_jump_req && irq_req && !bus_hold_req;
            end
            default: begin
                do_ex  = 1'b0;
                do_irq = 1'b0;
            end
        endcase
    end

    // Controller FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            st        <= CTRL_IDLE;
            cnt       <= 4'd0;
            jump_flag <= JUMP_DISABLE;
            jump_addr <= '0;
            hold_flag <= '0;
            flush     <= 1'b0;
            irq_ack   <= 1'b0;
            irq_epc   <= '0;
        end else begin
            jump_flag <= JUMP_DISABLE;
            irq_ack   <= 1'b0;
            flush     <= 1'b0;
            hold_flag <= HOLD_W'(HOLD_NONE);
            if (do_ex || do_irq) begin
                // Redirect: holds are ignored on the redirect cycle.
                jump_flag <= JUMP_ENABLE;
                jump_addr <= do_ex ? ex_jump_addr : irq_vector;
                flush     <= 1'b1;
                cnt       <= CNT_INIT;
                st        <= CTRL_FLUSH;
                if (do_irq) begin
                    irq_ack <= 1'b1;
                    irq_epc <= cur_pc;
                end
            end else begin
                case (st)
                    CTRL_IDLE: begin
                        if (irq_req && !ex_hold_req) begin
                            // Interrupt blocked by a bus wait: freeze the front end until it clears.
                            hold_flag <= HOLD_W'(HOLD_FRONT);
                            st        <= CTRL_IRQ_WAIT;
                        end else begin
                            hold_flag <= HOLD_W'(idle_hold(ex_hold_req, bus_hold_req));
                        end
                    end
                    CTRL_IRQ_WAIT: begin
                        hold_flag <= HOLD_W'(HOLD_FRONT);
                        if (!irq_req) st <= CTRL_IDLE;
                    end
                    CTRL_FLUSH: begin
                        if (bus_hold_req) begin
                            // Bus wait stretches the flush; the counter is frozen.
                            flush     <= 1'b1;
                            hold_flag <= HOLD_W'(HOLD_FRONT);
                        end else if (cnt == 4'd0) begin
                            st <= CTRL_IDLE;
                        end else begin
                            flush <= 1'b1;
                            cnt   <= cnt - 4'd1;
                        end
                    end
                    default: st <= CTRL_IDLE;
                endcase
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf #(
        .HOLD_W(HOLD_W)
    ) u_perf (
        .clk          (clk),
        .rst          (rst),
        .jump_flag    (jump_flag),
        .hold_flag    (hold_flag),
        .redirect_cnt (redirect_cnt),
        .stall_cnt    (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-scenario tasks drive a stimulus
// plan; expected outputs go into exp_q as each row is driven and are
// popped and compared one cycle later.
module tb_pipe_ctrl;

    localparam int ADDR_W       = 32;
    localparam int HOLD_W       = 3;
    localparam int FLUSH_CYCLES = 2;
    localparam int OUT_W        = 2 * ADDR_W + HOLD_W + 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_jump_req;
    logic [ADDR_W-1:0] ex_jump_addr;
    logic              ex_hold_req;
    logic              bus_hold_req;
    logic              irq_req;
    logic [ADDR_W-1:0] irq_vector;
    logic [ADDR_W-1:0] cur_pc;
    logic              jump_flag;
    logic [ADDR_W-1:0] jump_addr;
    logic [HOLD_W-1:0] hold_flag;
    logic              flush;
    logic              irq_ack;
    logic [ADDR_W-1:0] irq_epc;
    logic [1:0]        state;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]       redirect_cnt;
    logic [31:0]       stall_cnt;
`endif

    pipe_ctrl #(
        .ADDR_W       (ADDR_W),
        .HOLD_W       (HOLD_W),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_jump_req  (ex_jump_req),
        .ex_jump_addr (ex_jump_addr),
        .ex_hold_req  (ex_hold_req),
        .bus_hold_req (bus_hold_req),
        .irq_req      (irq_req),
        .irq_vector   (irq_vector),
        .cur_pc       (cur_pc),
        .jump_flag    (jump_flag),
        .jump_addr    (jump_addr),
        .hold_flag    (hold_flag),
        .flush        (flush),
        .irq_ack      (irq_ack),
        .irq_epc      (irq_epc),
        .state        (state)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .redirect_cnt (redirect_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    // Clock / reset block
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        jr;
        logic [31:0] ja;
        logic        eh;
        logic        bh;
        logic        irq;
    } stim_t;

    logic [OUT_W-1:0] exp_q[$];
    stim_t            plan_s[$];
    logic [OUT_W-1:0] plan_e[$];
    int               n_chk = 0;
    int               n_err = 0;

    function automatic stim_t st(input logic r, input logic jr, input logic [31:0] ja,
                                 input logic eh, input logic bh, input logic irq);
        stim_t s;
        s.rst = r; s.jr = jr; s.ja = ja; s.eh = eh; s.bh = bh; s.irq = irq;
        return s;
    endfunction

    function automatic logic [OUT_W-1:0] pk(input logic jf, input logic [31:0] ja, input logic [2:0] hf,
                                            input logic fl, input logic ack, input logic [31:0] epc);
        return {jf, ja, hf, fl, ack, epc};
    endfunction

    function automatic logic [OUT_W-1:0] act_out();
        return {jump_flag, jump_addr, hold_flag, flush, irq_ack, irq_epc};
    endfunction

    // Driver tasks
    task automatic apply(input stim_t s);
        rst          = s.rst;
        ex_jump_req  = s.jr;
        ex_jump_addr = s.ja;
        ex_hold_req  = s.eh;
        bus_hold_req = s.bh;
        irq_req      = s.irq;
    endtask

    task automatic plan(input stim_t s, input logic [OUT_W-1:0] e);
        plan_s.push_back(s);
        plan_e.push_back(e);
    endtask

    task automatic test_reset();
        logic [OUT_W-1:0] got, want;
        cur_pc = 32'h77; irq_vector = 32'h300;
        plan_s.delete(); plan_e.delete();
        plan(st(0, 1, 32'h99, 1, 1, 1), pk(0, 32'h0, 3'b000, 0, 0, 32'h0));
        plan(st(1, 0, 32'h0, 0, 0, 0),  pk(0, 32'h0, 3'b000, 0, 0, 32'h0));
        for (int i = 0; i < plan_s.size(); i++) begin
            apply(plan_s[i]); exp_q.push_back(plan_e[i]);
            @(posedge clk); #1;
            got = act_out(); want = exp_q.pop_front(); n_chk++;
            if (got !== want) begin
                n_err++; $display("FAIL reset step %0d: got %h want %h", i, got, want);
            end
            if (i == 0) begin
                n_chk++;
                if (state !== 2'd0) begin
                    n_err++; $display("FAIL reset_state: got %0d want 0", state);
                end
            end
        end
    endtask

    task automatic test_ex_jump();
        logic [OUT_W-1:0] got, want;
        cur_pc = 32'h10; irq_vector = 32'h0;
        plan_s.delete(); plan_e.delete();
        plan(st(1, 1, 32'h40, 1, 0, 0), pk(1, 32'h40, 3'b000, 1, 0, 32'h0));
        plan(st(1, 1, 32'h80, 0, 0, 0), pk(0, 32'h40, 3'b000, 1, 0, 32'h0));
        plan(st(1, 0, 32'h0, 0, 0, 0),  pk(0, 32'h40, 3'b000, 0, 0, 32'h0));
        plan(st(1, 0, 32'h0, 0, 0, 0),  pk(0, 32'h40, 3'b000, 0, 0, 32'h0));
        for (int i = 0; i < plan_s.size(); i++) begin
            apply(plan_s[i]); exp_q.push_back(plan_e[i]);
            @(posedge clk); #1;
            got = act_out(); want = exp_q.pop_front(); n_chk++;
            if (got !== want) begin
                n_err++; $display("FAIL ex_jump step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_stalls();
        logic [OUT_W-1:0] got, want;
        plan_s.delete(); plan_e.delete();
        plan(st(1, 0, 32'h0, 1, 0, 0),  pk(0, 32'h40, 3'b111, 0, 0, 32'h0));
        plan(st(1, 0, 32'h0, 0, 1, 0),  pk(0, 32'h40, 3'b011, 0, 0, 32'h0));
        plan(st(1, 0, 32'h0, 1, 1, 0),  pk(0, 32'h40, 3'b111, 0, 0, 32'h0));
        plan(st(1, 0, 32'h0, 0, 0, 0),  pk(0, 32'h40, 3'b000, 0, 0, 32'h0));
        plan(st(1, 1, 32'h44, 0, 0, 0), pk(1, 32'h44, 3'b000, 1, 0, 32'h0));
        plan(st(1, 0, 32'h0, 0, 1, 0),  pk(0, 32'h44, 3'b011, 1, 0, 32'h0));
        plan(st(1, 0, 32'h0, 0, 1, 0),  pk(0, 32'h44, 3'b011, 1, 0, 32'h0));
        plan(st(1, 0, 32'h0, 0, 0, 0),  pk(0, 32'h44, 3'b000, 1, 0, 32'h0));
        plan(st(1, 0, 32'h0, 0, 0, 0),  pk(0, 32'h44, 3'b000, 0, 0, 32'h0));
        plan(st(1, 0, 32'h0, 0, 0, 0),  pk(0, 32'h44, 3'b000, 0, 0, 32'h0));
        for (int i = 0; i < plan_s.size(); i++) begin
            apply(plan_s[i]); exp_q.push_back(plan_e[i]);
            @(posedge clk); #1;
            got = act_out(); want = exp_q.pop_front(); n_chk++;
            if (got !== want) begin
                n_err++; $display("FAIL stalls step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_irq_bus_wait();
        logic [OUT_W-1:0] got, want;
        cur_pc = 32'h1234; irq_vector = 32'h300;
        plan_s.delete(); plan_e.delete();
        plan(st(1, 0, 32'h0, 1, 0, 1), pk(0, 32'h44, 3'b111, 0, 0, 32'h0));
        plan(st(1, 0, 32'h0, 0, 1, 1), pk(0, 32'h44, 3'b011, 0, 0, 32'h0));
        plan(st(1, 0, 32'h0, 0, 1, 1), pk(0, 32'h44, 3'b011, 0, 0, 32'h0));
        plan(st(1, 0, 32'h0, 0, 1, 1), pk(0, 32'h44, 3'b011, 0, 0, 32'h0));
        plan(st(1, 0, 32'h0, 0, 0, 1), pk(1, 32'h300, 3'b000, 1, 1, 32'h1234));
        plan(st(1, 0, 32'h0, 0, 0, 0), pk(0, 32'h300, 3'b000, 1, 0, 32'h1234));
        plan(st(1, 0, 32'h0, 0, 0, 0), pk(0, 32'h300, 3'b000, 0, 0, 32'h1234));
        for (int i = 0; i < plan_s.size(); i++) begin
            apply(plan_s[i]); exp_q.push_back(plan_e[i]);
            @(posedge clk); #1;
            got = act_out(); want = exp_q.pop_front(); n_chk++;
            if (got !== want) begin
                n_err++; $display("FAIL irq_bus_wait step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [OUT_W-1:0] got, want;
        cur_pc = 32'h2000; irq_vector = 32'h200;
        plan_s.delete(); plan_e.delete();
        plan(st(1, 1, 32'h40, 0, 0, 1), pk(1, 32'h40, 3'b000, 1, 0, 32'h1234));
        plan(st(1, 0, 32'h0, 0, 0, 1),  pk(0, 32'h40, 3'b000, 1, 0, 32'h1234));
        plan(st(1, 0, 32'h0, 0, 0, 1),  pk(0, 32'h40, 3'b000, 0, 0, 32'h1234));
        plan(st(1, 0, 32'h0, 0, 0, 1),  pk(1, 32'h200, 3'b000, 1, 1, 32'h2000));
        plan(st(1, 0, 32'h0, 0, 0, 0),  pk(0, 32'h200, 3'b000, 1, 0, 32'h2000));
        plan(st(1, 0, 32'h0, 0, 0, 0),  pk(0, 32'h200, 3'b000, 0, 0, 32'h2000));
        for (int i = 0; i < plan_s.size(); i++) begin
            apply(plan_s[i]); exp_q.push_back(plan_e[i]);
            @(posedge clk); #1;
            got = act_out(); want = exp_q.pop_front(); n_chk++;
            if (got !== want) begin
                n_err++; $display("FAIL simultaneous step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [OUT_W-1:0] got, want;
        cur_pc = 32'h3000; irq_vector = 32'h400;
        plan_s.delete(); plan_e.delete();
        plan(st(1, 0, 32'h0, 0, 1, 1),  pk(0, 32'h200, 3'b011, 0, 0, 32'h2000));
        plan(st(1, 1, 32'h50, 0, 1, 1), pk(1, 32'h50, 3'b000, 1, 0, 32'h2000));
        plan(st(1, 0, 32'h0, 0, 0, 1),  pk(0, 32'h50, 3'b000, 1, 0, 32'h2000));
        plan(st(1, 0, 32'h0, 0, 0, 1),  pk(0, 32'h50, 3'b000, 0, 0, 32'h2000));
        plan(st(1, 0, 32'h0, 0, 0, 1),  pk(1, 32'h400, 3'b000, 1, 1, 32'h3000));
        plan(st(1, 0, 32'h0, 0, 0, 0),  pk(0, 32'h400, 3'b000, 1, 0, 32'h3000));
        plan(st(1, 0, 32'h0, 0, 0, 0),  pk(0, 32'h400, 3'b000, 0, 0, 32'h3000));
        for (int i = 0; i < plan_s.size(); i++) begin
            apply(plan_s[i]); exp_q.push_back(plan_e[i]);
            @(posedge clk); #1;
            got = act_out(); want = exp_q.pop_front(); n_chk++;
            if (got !== want) begin
                n_err++; $display("FAIL back_to_back step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        logic [OUT_W-1:0] got, want;
        plan_s.delete(); plan_e.delete();
        plan(st(1, 1, 32'h100, 0, 0, 0), pk(1, 32'h100, 3'b000, 1, 0, 32'h3000));
        plan(st(0, 0, 32'h0, 0, 0, 0),   pk(0, 32'h0, 3'b000, 0, 0, 32'h0));
        plan(st(1, 0, 32'h0, 0, 0, 0),   pk(0, 32'h0, 3'b000, 0, 0, 32'h0));
        plan(st(1, 0, 32'h0, 0, 0, 0),   pk(0, 32'h0, 3'b000, 0, 0, 32'h0));
        for (int i = 0; i < plan_s.size(); i++) begin
            apply(plan_s[i]); exp_q.push_back(plan_e[i]);
            @(posedge clk); #1;
            got = act_out(); want = exp_q.pop_front(); n_chk++;
            if (got !== want) begin
                n_err++; $display("FAIL reset_mid_flush step %0d: got %h want %h", i, got, want);
            end
            if (i == 1) begin
                n_chk++;
                if (state !== 2'd0) begin
                    n_err++; $display("FAIL reset_mid_flush_state: got %0d want 0", state);
                end
            end
        end
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        // Counters start from the reset applied in the previous scenario.
        for (int r = 0; r < 3; r++) begin
            apply(st(1, 1, 32'h60, 0, 0, 0)); @(posedge clk); #1;
            apply(st(1, 0, 32'h0, 0, 0, 0));  @(posedge clk); #1;
            @(posedge clk); #1;
        end
        for (int s = 0; s < 5; s++) begin
            apply(st(1, 0, 32'h0, 1, 0, 0)); @(posedge clk); #1;
        end
        apply(st(1, 0, 32'h0, 0, 0, 0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_chk++;
        if (redirect_cnt !== 32'd3) begin
            n_err++; $display("FAIL perf_redirect: got %0d want 3", redirect_cnt);
        end
        n_chk++;
        if (stall_cnt !== 32'd5) begin
            n_err++; $display("FAIL perf_stall: got %0d want 5", stall_cnt);
        end
    endtask
`endif

    initial begin
        apply(st(0, 0, 32'h0, 0, 0, 0));
        cur_pc = 32'h0; irq_vector = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_ex_jump();
        test_stalls();
        test_irq_bus_wait();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_flush();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
